// File: rtl/sram_mem_port.sv
// Memory-stage port to a 16-bit asynchronous SRAM: each 32-bit load or store is
// split into a low and a high halfword phase, freezing the pipeline meanwhile.
module sram_mem_port #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic        ready,
    output logic [31:0] read_data,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_WE_N,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]  WAIT_LAST = WAIT_CYCLES[3:0];
    localparam logic [31:0] BASE      = BASE_ADDR[31:0];

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        write_q;
    logic        req;
    logic        phase_last;
    logic [16:0] word;

    assign req        = MEM_R_EN | MEM_W_EN;
    assign phase_last = (counter == WAIT_LAST);
    assign word       = 17'((addr_q - BASE) >> 2);
    assign ready      = ~req | (state == DONE);
    assign fsm_state  = state;

    // State register, phase counter, request latches and load capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            write_q   <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_next;
            if ((state == LOW || state == HIGH) && !phase_last) begin
                counter <= counter + 4'd1;
            end else begin
                counter <= 4'd0;
            end
            if (state == IDLE && req) begin
                addr_q  <= ALU_result;
                data_q  <= ST_val;
                write_q <= MEM_W_EN;
            end
            // Load halves are sampled on the final cycle of each phase.
            if (!write_q && phase_last && state == LOW) begin
                read_data[15:0] <= SRAM_DQ_IN;
            end
            if (!write_q && phase_last && state == HIGH) begin
                read_data[31:16] <= SRAM_DQ_IN;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = LOW;
            LOW:  if (phase_last) state_next = HIGH;
            HIGH: if (phase_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs; reset forces the idle bus at once so an aborted store
    // cannot finish its WE pulse.
    always_comb begin
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_OUT = 16'd0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        if (rst) begin
            case (state)
                LOW: begin
                    SRAM_ADDR = {word, 1'b0};
                    if (write_q) begin
                        SRAM_DQ_OUT = data_q[15:0];
                        SRAM_DQ_OE  = 1'b1;
                        SRAM_WE_N   = phase_last;
                    end
                end
                HIGH: begin
                    SRAM_ADDR = {word, 1'b1};
                    if (write_q) begin
                        SRAM_DQ_OUT = data_q[31:16];
                        SRAM_DQ_OE  = 1'b1;
                        SRAM_WE_N   = phase_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
